// File: rtl/lfsr_rand_range_if.sv
// lfsr_rand_range_if: request/result bundle for the bounded random source.
// master drives requests and consumes results; slave is the generator.
interface lfsr_rand_range_if #(
    parameter int WIDTH = 10,
    parameter int OUT_W = 8
);
    logic             req;
    logic [OUT_W-1:0] limit;
    logic             seed_load;
    logic [WIDTH-1:0] seed_in;
    logic             rand_valid;
    logic             rand_ready;
    logic [OUT_W-1:0] rand_out;
    logic             fallback;
    logic [WIDTH-1:0] lfsr_state;

    modport master (
        output req,
        output limit,
        output seed_load,
        output seed_in,
        output rand_ready,
        input  rand_valid,
        input  rand_out,
        input  fallback,
        input  lfsr_state
    );

    modport slave (
        input  req,
        input  limit,
        input  seed_load,
        input  seed_in,
        input  rand_ready,
        output rand_valid,
        output rand_out,
        output fallback,
        output lfsr_state
    );
endinterface

// File: rtl/lfsr_rand_range.sv
// lfsr_rand_range: free-running Fibonacci LFSR plus bounded-value front end.
// Seed loading is compiled in only when RANDGEN_SEED_LOAD_EN is defined.
module lfsr_rand_range #(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(10'h204),
    parameter int               OUT_W     = 8,
    parameter int               MAX_TRIES = 4
) (
    input  logic             clk,
    input  logic             rstn,
    lfsr_rand_range_if.slave bus
);

    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_lfsr_adv;
    logic [WIDTH-1:0] w_lfsr_nxt;
    logic             w_fb;

    logic [1:0]       r_state;
    logic [OUT_W-1:0] r_lim;
    logic [TW-1:0]    r_tries;
    logic [OUT_W-1:0] r_out;
    logic             r_fallback;
    logic             r_valid;

    logic [1:0]       w_state_nxt;
    logic [OUT_W-1:0] w_lim_nxt;
    logic [TW-1:0]    w_tries_nxt;
    logic [OUT_W-1:0] w_out_nxt;
    logic             w_fallback_nxt;
    logic             w_valid_nxt;

    logic [OUT_W-1:0] w_cand;
    logic             w_accept;
    logic             w_last;

    assign w_fb       = ^(r_lfsr & TAPS);
    assign w_lfsr_adv = {r_lfsr[WIDTH-2:0], w_fb};

`ifdef RANDGEN_SEED_LOAD_EN
    logic [WIDTH-1:0] w_seed_val;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign w_seed_val = (bus.seed_in == '0) ? WIDTH'(1) : bus.seed_in;
    assign w_lfsr_nxt = bus.seed_load ? w_seed_val : w_lfsr_adv;
`else
    logic w_unused_seed;

    assign w_unused_seed = ^{bus.seed_load, bus.seed_in};
    assign w_lfsr_nxt    = w_lfsr_adv;
`endif

    // LFSR register: advances every cycle, restarts from 1 on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lfsr <= WIDTH'(1);
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    assign w_cand   = r_lfsr[OUT_W-1:0];
    assign w_accept = (w_cand <= r_lim);
    assign w_last   = (r_tries == LAST_TRY);

    // Request FSM next-state: rejection sampling with bounded retries.
    always_comb begin
        w_state_nxt    = r_state;
        w_lim_nxt      = r_lim;
        w_tries_nxt    = r_tries;
        w_out_nxt      = r_out;
        w_fallback_nxt = r_fallback;
        w_valid_nxt    = r_valid;
        unique case (r_state)
            S_IDLE: begin
                w_valid_nxt = 1'b0;
                if (bus.req) begin
                    w_lim_nxt   = bus.limit;
                    w_tries_nxt = '0;
                    w_state_nxt = S_DRAW;
                end
            end
            S_DRAW: begin
                if (w_accept) begin
                    w_out_nxt      = w_cand;
                    w_fallback_nxt = 1'b0;
                    w_valid_nxt    = 1'b1;
                    w_state_nxt    = S_HOLD;
                end else if (w_last) begin
                    w_out_nxt      = r_lim;
                    w_fallback_nxt = 1'b1;
                    w_valid_nxt    = 1'b1;
                    w_state_nxt    = S_HOLD;
                end else begin
                    w_tries_nxt = r_tries + TW'(1);
                end
            end
            S_HOLD: begin
                if (bus.rand_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request FSM registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_lim      <= '0;
            r_tries    <= '0;
            r_out      <= '0;
            r_fallback <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lim      <= w_lim_nxt;
            r_tries    <= w_tries_nxt;
            r_out      <= w_out_nxt;
            r_fallback <= w_fallback_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign bus.rand_valid = r_valid;
    assign bus.rand_out   = r_out;
    assign bus.fallback   = r_fallback;
    assign bus.lfsr_state = r_lfsr;

endmodule
